// File: rtl/lfsr_seq_checker_if.sv
// Sample/status bundle between the 24-bit LFSR demo path and its sequence checker.
// master drives the sample strobe, word and clear; slave returns lock/error/lockup/stall status.
interface lfsr_seq_checker_if #(
    parameter int NUM_BITS  = 24,
    parameter int ERR_CNT_W = 16
);
    logic                 valid;
    logic [NUM_BITS-1:0]  data;
    logic                 clear;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 lockup;
    logic [NUM_BITS-1:0]  expected;
    logic                 stall;

    modport master (
        output valid, data, clear,
        input  locked, err_pulse, err_count, lockup, expected, stall
    );

    modport slave (
        input  valid, data, clear,
        output locked, err_pulse, err_count, lockup, expected, stall
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Locks onto a 24-bit XNOR LFSR stream, counts mismatches, flags all-ones lockup.
// Status registered one cycle after the sampling edge; no backpressure, every strobe is consumed.
// Optional LFSR_CHK_WATCHDOG_EN adds an idle watchdog that sets a sticky stall flag.
module lfsr_seq_checker #(
    parameter int NUM_BITS    = 24,
    parameter int LOCK_COUNT  = 4,
    parameter int LOSS_COUNT  = 3,
    parameter int ERR_CNT_W   = 16,
    parameter int WDOG_CYCLES = 16777215
) (
    input  logic               clk,
    input  logic               rst_n,
    lfsr_seq_checker_if.slave  bus
);
    if (NUM_BITS != 24) begin : g_bad_width
        $error("lfsr_seq_checker: NUM_BITS must be 24");
    end
    if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || LOSS_COUNT < 1 || LOSS_COUNT > 15) begin : g_bad_count
        $error("lfsr_seq_checker: LOCK_COUNT and LOSS_COUNT must be in 1..15");
    end
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 16777215) begin : g_bad_wdog
        $error("lfsr_seq_checker: WDOG_CYCLES must fit in 24 bits");
    end

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t               state;
    logic [NUM_BITS-1:0]  ref_word;
    logic [3:0]           good_cnt;
    logic [3:0]           bad_cnt;
    logic [ERR_CNT_W-1:0] err_count_q;
    logic                 locked_q;
    logic                 err_pulse_q;
    logic                 lockup_q;
    logic                 wdog_trip;
    logic [NUM_BITS-1:0]  predicted;
    logic                 match;
    logic                 all_ones;

    function automatic logic [23:0] lfsr_next(input logic [23:0] d);
        return {d[22:0], ~(d[23] ^ d[22] ^ d[21] ^ d[16])};
    endfunction

    assign predicted = lfsr_next(ref_word);
    assign match     = (bus.data == predicted);
    assign all_ones  = &bus.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            ref_word    <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.valid && all_ones) begin
                // Lockup word is never evaluated as a match or mismatch.
                lockup_q <= 1'b1;
                state    <= HUNT;
                locked_q <= 1'b0;
                good_cnt <= '0;
            end else if (bus.valid) begin
                unique case (state)
                    HUNT: begin
                        ref_word <= bus.data;
                        good_cnt <= '0;
                        state    <= VERIFY;
                    end
                    VERIFY: begin
                        ref_word <= bus.data;
                        if (!match) begin
                            good_cnt <= '0;
                        end else if (good_cnt == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            ref_word <= bus.data;
                            bad_cnt  <= '0;
                        end else begin
                            // Flywheel on the prediction so one bad word is not propagated.
                            ref_word    <= predicted;
                            err_pulse_q <= 1'b1;
                            if (!(&err_count_q)) err_count_q <= err_count_q + 1'b1;
                            if (bad_cnt == LOSS_LAST) begin
                                state    <= HUNT;
                                locked_q <= 1'b0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end else if (wdog_trip) begin
                state    <= HUNT;
                locked_q <= 1'b0;
            end
            if (bus.clear) begin
                err_count_q <= '0;
                lockup_q    <= 1'b0;
            end
        end
    end

`ifdef LFSR_CHK_WATCHDOG_EN
    localparam logic [23:0] WDOG_LAST = 24'(WDOG_CYCLES - 1);
    logic [23:0] idle_cnt;
    logic        stall_q;

    assign wdog_trip = (state == LOCKED) && !bus.valid && (idle_cnt == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (state != LOCKED || bus.valid || wdog_trip) idle_cnt <= '0;
            else idle_cnt <= idle_cnt + 24'd1;
            if (bus.clear) stall_q <= 1'b0;
            else if (wdog_trip) stall_q <= 1'b1;
        end
    end

    assign bus.stall = stall_q;
`else
    assign wdog_trip = 1'b0;
    assign bus.stall = 1'b0;
`endif

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.lockup    = lockup_q;
    assign bus.expected  = predicted;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Randomized and directed bench for lfsr_seq_checker against a behavioural model.
module tb_lfsr_seq_checker;
    localparam int W   = 24;
    localparam int ECW = 16;
    localparam int WD  = 20;
    localparam int MH = 0, MV = 1, ML = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_seq_checker_if #(.NUM_BITS(W), .ERR_CNT_W(ECW)) bus ();

    lfsr_seq_checker #(
        .NUM_BITS(W), .LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_CNT_W(ECW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_mode, m_good, m_bad, m_idle, m_cnt;
    logic [23:0] m_ref;
    logic        m_pulse, m_lockup, m_stall;

    function automatic logic [23:0] nxt(input logic [23:0] d);
        logic fb;
        fb = ~(d[23] ^ d[22] ^ d[21] ^ d[16]);
        return {d[22:0], fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode = MH; m_good = 0; m_bad = 0; m_idle = 0; m_cnt = 0;
        m_ref = '0; m_pulse = 1'b0; m_lockup = 1'b0; m_stall = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [23:0] d, input logic c);
        m_pulse = 1'b0;
        if (v && d == 24'hFFFFFF) begin
            m_lockup = 1'b1;
            m_mode = MH;
            m_good = 0;
        end else if (v) begin
            if (m_mode == MH) begin
                m_ref = d; m_good = 0; m_mode = MV;
            end else if (m_mode == MV) begin
                if (d == nxt(m_ref)) begin
                    m_good++;
                    if (m_good >= 4) begin m_mode = ML; m_bad = 0; m_good = 0; end
                end else begin
                    m_good = 0;
                end
                m_ref = d;
            end else begin
                if (d == nxt(m_ref)) begin
                    m_ref = d; m_bad = 0;
                end else begin
                    m_ref = nxt(m_ref);
                    m_pulse = 1'b1;
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                    m_bad++;
                    if (m_bad >= 3) m_mode = MH;
                end
            end
        end
`ifdef LFSR_CHK_WATCHDOG_EN
        if (m_mode == ML && !v) begin
            m_idle++;
            if (m_idle == WD) begin m_stall = 1'b1; m_mode = MH; m_idle = 0; end
        end else begin
            m_idle = 0;
        end
`endif
        if (c) begin m_cnt = 0; m_lockup = 1'b0; m_stall = 1'b0; end
    endtask

    task automatic cmp_model();
        chk("locked",    32'(bus.locked),    32'(m_mode == ML));
        chk("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        chk("err_count", 32'(bus.err_count), 32'(m_cnt));
        chk("lockup",    32'(bus.lockup),    32'(m_lockup));
        chk("expected",  32'(bus.expected),  32'(nxt(m_ref)));
        chk("stall",     32'(bus.stall),     32'(m_stall));
    endtask

    task automatic step(input logic v, input logic [23:0] d, input logic c);
        bus.valid = v; bus.data = d; bus.clear = c;
        model_step(v, d, c);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic feed_chain(input logic [23:0] seed, input int n);
        logic [23:0] g;
        g = seed;
        for (int i = 0; i < n; i++) begin
            step(1'b1, g, 1'b0);
            g = nxt(g);
        end
    endtask

    initial begin
        logic [23:0] g, d;
        logic v, c;
        int r, gap;

        bus.valid = 1'b0; bus.data = '0; bus.clear = 1'b0;
        m_reset();

        chk("pin_next_0",   32'(nxt(24'h000000)), 32'h000001);
        chk("pin_next_f",   32'(nxt(24'h00000F)), 32'h00001F);
        chk("pin_next_ff",  32'(nxt(24'hFFFFFF)), 32'hFFFFFF);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_model();
        chk("rst_expected", 32'(bus.expected), 32'h000001);
        chk("rst_locked",   32'(bus.locked), 32'h0);

        // Lock acquisition
        step(1'b1, 24'h000000, 1'b0);
        step(1'b1, 24'h000001, 1'b0);
        step(1'b1, 24'h000003, 1'b0);
        step(1'b1, 24'h000007, 1'b0);
        chk("lock_not_yet", 32'(bus.locked), 32'h0);
        step(1'b1, 24'h00000F, 1'b0);
        chk("lock_5th", 32'(bus.locked), 32'h1);
        chk("lock_cnt", 32'(bus.err_count), 32'h0);

        // Single error while locked
        step(1'b1, 24'h00001E, 1'b0);
        chk("err1_pulse", 32'(bus.err_pulse), 32'h1);
        chk("err1_cnt",   32'(bus.err_count), 32'h1);
        chk("err1_lock",  32'(bus.locked), 32'h1);
        step(1'b1, 24'h00003F, 1'b0);
        chk("err1_nopulse", 32'(bus.err_pulse), 32'h0);
        chk("err1_accept",  32'(bus.expected), 32'h00007F);

        // Loss of lock after a clear
        step(1'b0, 24'h0, 1'b1);
        chk("clr_cnt", 32'(bus.err_count), 32'h0);
        step(1'b1, 24'h123456, 1'b0);
        step(1'b1, 24'h123456, 1'b0);
        chk("loss_still", 32'(bus.locked), 32'h1);
        step(1'b1, 24'h123456, 1'b0);
        chk("loss_unlock", 32'(bus.locked), 32'h0);
        chk("loss_cnt",    32'(bus.err_count), 32'h3);
        feed_chain(24'h00ABCD, 5);
        chk("relock", 32'(bus.locked), 32'h1);

        // Lockup then clear
        step(1'b1, 24'hFFFFFF, 1'b0);
        chk("lockup_flag", 32'(bus.lockup), 32'h1);
        chk("lockup_lock", 32'(bus.locked), 32'h0);
        chk("lockup_cnt",  32'(bus.err_count), 32'h3);
        step(1'b0, 24'h0, 1'b1);
        chk("clr_lockup", 32'(bus.lockup), 32'h0);
        chk("clr_cnt2",   32'(bus.err_count), 32'h0);

        // Watchdog
        feed_chain(24'h000100, 5);
        chk("wd_locked", 32'(bus.locked), 32'h1);
        repeat (19) step(1'b0, 24'h0, 1'b0);
        chk("wd_19", 32'(bus.locked), 32'h1);
        step(1'b0, 24'h0, 1'b0);
`ifdef LFSR_CHK_WATCHDOG_EN
        chk("wd_stall",  32'(bus.stall), 32'h1);
        chk("wd_unlock", 32'(bus.locked), 32'h0);
`else
        chk("wd_stall",  32'(bus.stall), 32'h0);
        chk("wd_unlock", 32'(bus.locked), 32'h1);
`endif
        step(1'b0, 24'h0, 1'b1);
        chk("clr_stall", 32'(bus.stall), 32'h0);

        // Randomized traffic
        g = 24'($urandom_range(0, 24'hFFFFFE));
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (gap == 0 && $urandom_range(0, 299) == 0) gap = 25;
            if (gap > 0) begin
                v = 1'b0; gap--;
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 60) == 0);
            r = $urandom_range(0, 99);
            if (r < 85) d = g;
            else if (r < 98) d = 24'($urandom);
            else d = 24'hFFFFFF;
            if (v) g = nxt(g);
            if ($urandom_range(0, 199) == 0) g = 24'($urandom_range(0, 24'hFFFFFE));
            step(v, d, c);
        end

        // Reset mid-operation, then relock
        bus.valid = 1'b0; bus.clear = 1'b0;
        rst_n = 1'b0;
        m_reset();
        #1;
        cmp_model();
        chk("midrst_expected", 32'(bus.expected), 32'h000001);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp_model();
        feed_chain(24'h0F0F0F, 4);
        chk("midrst_4", 32'(bus.locked), 32'h0);
        feed_chain(nxt(nxt(nxt(nxt(24'h0F0F0F)))), 1);
        chk("midrst_5", 32'(bus.locked), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
